pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage integer core. It combines stall requests from decode, execute and memory into one stall vector for the PC and pipeline registers. It sequences multi-cycle execute operations with a countdown, and it flushes the pipeline on exceptions or on a memory-bus stall timeout. It sits beside the decode/execute/memory stages and drives the hold inputs of every pipeline register.

---
 rtl/core_pkg.sv | 31 +++
 rtl/stall_timeout.sv | 27 ++
 rtl/pipe_ctrl.sv | 98 +++++++++
 tb/tb_pipe_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the integer core pipeline control: FSM states,
// stall-vector encodings, stage indices and the default exception vector.
package core_pkg;

    typedef enum logic [1:0] {
        RUN,
        MC_BUSY,
        FLUSH
    } pc_state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IF_ID = 1;
    localparam int unsigned STG_ID_EX = 2;
    localparam int unsigned STG_EX_MEM = 3;
    localparam int unsigned STG_MEM_WB = 4;
    localparam int unsigned STG_WB    = 5;
    localparam int unsigned NUM_STG   = 6;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

    // A requested length of 0 behaves as a single-cycle operation.
    function automatic logic [5:0] mc_cnt_init(input logic [5:0] n);
        return (n == 6'd0) ? 6'd0 : n - 6'd1;
    endfunction

endpackage

// File: rtl/stall_timeout.sv
// Counts consecutive memory-stall cycles and flags a bus timeout.
module stall_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_stallreq_i,
    input  logic clr,
    output logic expire_o
);

    logic [7:0] tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (clr || !mem_stallreq_i) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 8'd1;
        end
    end

    // Suppressed during the flush cycle, which restarts the count.
    assign expire_o = mem_stallreq_i && !clr && (tcnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences multi-cycle
// execute operations and flushes on exceptions or bus timeouts.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_stallreq_i,
    input  logic        ex_mc_start_i,
    input  logic [5:0]  ex_mc_cycles_i,
    input  logic        mem_stallreq_i,
    input  logic        excp_i,
    input  logic        bus_err_clr_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        ex_mc_busy_o,
    output logic        ex_mc_done_o,
    output logic        bus_err_o
);

    pc_state_t  state, state_n;
    logic [5:0] cnt, cnt_n;
    logic       ex_req;
    logic       expire;

    stall_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_stall_timeout (
        .clk           (clk),
        .reset         (reset),
        .mem_stallreq_i(mem_stallreq_i),
        .clr           (flush_o),
        .expire_o      (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bus_err_o <= expire || (bus_err_o && !bus_err_clr_i);
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ex_req       = 1'b0;
        ex_mc_done_o = 1'b0;

        case (state)
            RUN: begin
                if (ex_mc_start_i) begin
                    state_n = MC_BUSY;
                    cnt_n   = mc_cnt_init(ex_mc_cycles_i);
                    ex_req  = 1'b1;
                end
            end
            MC_BUSY: begin
                if (cnt == 6'd0) begin
                    ex_mc_done_o = 1'b1;
                    state_n      = RUN;
                end else begin
                    cnt_n  = cnt - 6'd1;
                    ex_req = 1'b1;
                end
            end
            FLUSH:   state_n = RUN;
            default: state_n = RUN;
        endcase

        // Exception or timeout overrides everything, including a same-cycle start.
        if (excp_i || expire) begin
            state_n = FLUSH;
            cnt_n   = '0;
        end
    end

    always_comb begin
        if (state == FLUSH)     stall_o = STALL_NONE;
        else if (mem_stallreq_i) stall_o = STALL_MEM;
        else if (ex_req)         stall_o = STALL_EX;
        else if (id_stallreq_i)  stall_o = STALL_ID;
        else                     stall_o = STALL_NONE;
    end

    assign flush_o      = (state == FLUSH);
    assign new_pc_o     = flush_o ? EXC_VECTOR : '0;
    assign ex_mc_busy_o = (state == MC_BUSY);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int unsigned TO      = 16;
    localparam logic [31:0] EXC_PC  = 32'h0000_0020;
    localparam logic [5:0]  S_NONE  = 6'b000000;
    localparam logic [5:0]  S_ID    = 6'b000111;
    localparam logic [5:0]  S_EX    = 6'b001111;
    localparam logic [5:0]  S_MEM   = 6'b011111;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_stallreq_i, ex_mc_start_i, mem_stallreq_i, excp_i, bus_err_clr_i;
    logic [5:0]  ex_mc_cycles_i;
    logic [5:0]  stall_o;
    logic        flush_o, ex_mc_busy_o, ex_mc_done_o, bus_err_o;
    logic [31:0] new_pc_o;

    int n_vec = 0;
    int n_mis = 0;

    // Model: an operation started at cycle T with length N is busy in
    // cycles T+1..T+N and completes at absolute cycle t_done = T+N.
    int cyc     = 0;
    bit m_flush = 0;
    bit m_active = 0;
    bit m_err   = 0;
    int t_done  = 0;
    int m_run   = 0;

    logic [5:0]  last_stall;
    logic        last_flush, last_busy, last_done, last_err;
    logic [31:0] last_pc;

    pipe_ctrl #(
        .EXC_VECTOR(EXC_PC),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_stallreq_i (id_stallreq_i),
        .ex_mc_start_i (ex_mc_start_i),
        .ex_mc_cycles_i(ex_mc_cycles_i),
        .mem_stallreq_i(mem_stallreq_i),
        .excp_i        (excp_i),
        .bus_err_clr_i (bus_err_clr_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .new_pc_o      (new_pc_o),
        .ex_mc_busy_o  (ex_mc_busy_o),
        .ex_mc_done_o  (ex_mc_done_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_flush  = 0;
        m_active = 0;
        m_err    = 0;
        m_run    = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input bit id, input bit st, input logic [5:0] n,
                        input bit mem, input bit ex, input bit clr);
        logic [5:0] e_stall;
        bit e_req, e_done, expire, nf;
        @(negedge clk);
        id_stallreq_i  = id;
        ex_mc_start_i  = st;
        ex_mc_cycles_i = n;
        mem_stallreq_i = mem;
        excp_i         = ex;
        bus_err_clr_i  = clr;
        #1;
        e_done = m_active && (cyc == t_done);
        e_req  = (!m_flush && !m_active && st) || (m_active && cyc < t_done);
        if (m_flush)    e_stall = S_NONE;
        else if (mem)   e_stall = S_MEM;
        else if (e_req) e_stall = S_EX;
        else if (id)    e_stall = S_ID;
        else            e_stall = S_NONE;
        expire = mem && !m_flush && (m_run == TO - 1);

        check_val("stall", 32'(stall_o), 32'(e_stall));
        check_val("flush", 32'(flush_o), 32'(m_flush));
        check_val("new_pc", new_pc_o, m_flush ? EXC_PC : 32'h0);
        check_val("busy", 32'(ex_mc_busy_o), 32'(m_active));
        check_val("done", 32'(ex_mc_done_o), 32'(e_done));
        check_val("bus_err", 32'(bus_err_o), 32'(m_err));
        last_stall = stall_o;
        last_flush = flush_o;
        last_pc    = new_pc_o;
        last_busy  = ex_mc_busy_o;
        last_done  = ex_mc_done_o;
        last_err   = bus_err_o;

        nf = ex || expire;
        if (nf) m_active = 0;
        else if (m_active && cyc == t_done) m_active = 0;
        else if (!m_flush && !m_active && st) begin
            m_active = 1;
            t_done   = cyc + ((n == 6'd0) ? 1 : int'(n));
        end
        m_run   = (m_flush || !mem) ? 0 : m_run + 1;
        m_err   = expire ? 1'b1 : (clr ? 1'b0 : m_err);
        m_flush = nf;
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 6'd0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        id_stallreq_i = 0; ex_mc_start_i = 0; ex_mc_cycles_i = '0;
        mem_stallreq_i = 0; excp_i = 0; bus_err_clr_i = 0;
        #2;
        check_val("rst_stall", 32'(stall_o), 32'(S_NONE));
        check_val("rst_flush", 32'(flush_o), 0);
        check_val("rst_pc", new_pc_o, 0);
        check_val("rst_busy", 32'(ex_mc_busy_o), 0);
        check_val("rst_done", 32'(ex_mc_done_o), 0);
        check_val("rst_err", 32'(bus_err_o), 0);
        #10 reset = 1'b0;
        model_reset();
        idle(2);

        // Load-use
        step(1, 0, 6'd0, 0, 0, 0);
        check_val("loaduse_T", 32'(last_stall), 32'(S_ID));
        idle(1);
        check_val("loaduse_T1", 32'(last_stall), 32'(S_NONE));

        // N=4
        step(0, 1, 6'd4, 0, 0, 0);
        check_val("n4_T_stall", 32'(last_stall), 32'(S_EX));
        idle(3);
        check_val("n4_T3_stall", 32'(last_stall), 32'(S_EX));
        idle(1);
        check_val("n4_T4_done", 32'(last_done), 1);
        check_val("n4_T4_stall", 32'(last_stall), 32'(S_NONE));
        idle(1);
        check_val("n4_T5_busy", 32'(last_busy), 0);

        // N=0 behaves as N=1
        step(0, 1, 6'd0, 0, 0, 0);
        check_val("n0_T_stall", 32'(last_stall), 32'(S_EX));
        idle(1);
        check_val("n0_T1_done", 32'(last_done), 1);
        idle(1);

        // mem stall during MC_BUSY
        step(0, 1, 6'd3, 1, 0, 0);
        check_val("mcmem_T_stall", 32'(last_stall), 32'(S_MEM));
        step(0, 0, 6'd0, 1, 0, 0);
        step(0, 0, 6'd0, 1, 0, 0);
        step(0, 0, 6'd0, 1, 0, 0);
        check_val("mcmem_done", 32'(last_done), 1);
        idle(1);

        // Exception at T+2 of N=5; start in the flush cycle is ignored
        step(0, 1, 6'd5, 0, 0, 0);
        idle(1);
        step(0, 0, 6'd0, 0, 1, 0);
        step(1, 1, 6'd3, 1, 0, 0);
        check_val("exc_flush", 32'(last_flush), 1);
        check_val("exc_pc", last_pc, 32'h20);
        check_val("exc_stall", 32'(last_stall), 32'(S_NONE));
        idle(1);
        check_val("exc_run", 32'(last_busy), 0);
        idle(4);

        // Bus timeout: flush in the 17th cycle of a held stall
        for (int i = 0; i < 16; i++) step(0, 0, 6'd0, 1, 0, 0);
        step(0, 0, 6'd0, 1, 0, 0);
        check_val("to_flush", 32'(last_flush), 1);
        check_val("to_err", 32'(last_err), 1);
        idle(3);
        check_val("to_sticky", 32'(last_err), 1);
        // set and clear in the same cycle keep the flag
        for (int i = 0; i < 15; i++) step(0, 0, 6'd0, 1, 0, 0);
        step(0, 0, 6'd0, 1, 0, 1);
        step(0, 0, 6'd0, 0, 0, 0);
        check_val("to_setclr", 32'(last_err), 1);
        step(0, 0, 6'd0, 0, 0, 1);
        idle(1);
        check_val("to_cleared", 32'(last_err), 0);

        // Async reset mid-MC_BUSY
        step(0, 1, 6'd10, 0, 0, 0);
        idle(2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("arst_busy", 32'(ex_mc_busy_o), 0);
        check_val("arst_stall", 32'(stall_o), 32'(S_NONE));
        check_val("arst_done", 32'(ex_mc_done_o), 0);
        check_val("arst_flush", 32'(flush_o), 0);
        #1 reset = 1'b0;
        model_reset();
        step(0, 1, 6'd2, 0, 0, 0);
        check_val("arst_restart", 32'(last_stall), 32'(S_EX));
        idle(3);

        // Random traffic in phases of light and heavy memory stalling
        for (int ph = 0; ph < 20; ph++) begin
            int unsigned mem_pct;
            mem_pct = (ph % 2 == 1) ? 95 : 20;
            for (int i = 0; i < 150; i++) begin
                logic [5:0] n;
                n = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     n,
                     $urandom_range(0, 99) < mem_pct,
                     $urandom_range(0, 63) == 0,
                     $urandom_range(0, 15) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
